// File: rtl/res_io_pkg.sv
// rtl/res_io_pkg.sv - shared constants, width helpers and word type for the RES1 output packer
package res_io_pkg;

  // Width of the RES1 external output bus, in bits per nibble.
  localparam int RES_W = 4;

  // Geometry that res_word_t is laid out for.
  localparam int DEF_NIBBLES = 8;

  // Bits needed to hold a nibble count from 0 to nibbles inclusive.
  function automatic int count_width(input int nibbles);
    return $clog2(nibbles + 1);
  endfunction

  // Bits needed to hold a FIFO occupancy from 0 to depth inclusive.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_CW = count_width(DEF_NIBBLES);

  // One buffered word: count sits above data, the same packing the FIFO stores.
  typedef struct packed {
    logic [DEF_CW-1:0]              count;
    logic [RES_W*DEF_NIBBLES-1:0]   data;
  } res_word_t;

endpackage

// File: rtl/res_word_fifo.sv
// rtl/res_word_fifo.sv - first-word-fall-through FIFO of packed {count, data} words
module res_word_fifo
  import res_io_pkg::*;
#(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  localparam int LW = level_width(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A pop frees a slot on the same edge, so a full FIFO still takes a push alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The head reads as zero while empty so stale storage never reaches the host.
  assign head = empty ? '0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; level tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      level <= level + LW'(1);
      else if (do_pop && !do_push) level <= level - LW'(1);
    end
  end

  // Storage needs no reset: the empty gate on head hides its contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/res_out_packer.sv
// rtl/res_out_packer.sv - packs strobed RES1 output nibbles into words and hands them to a host
module res_out_packer
  import res_io_pkg::*;
#(
  parameter int NIBBLES    = 8,
  parameter int FIFO_DEPTH = 4,
  localparam int CW = count_width(NIBBLES),
  localparam int LW = level_width(FIFO_DEPTH),
  localparam int DW = RES_W * NIBBLES
) (
  input  logic             UserCLK,
  input  logic             RESETn,
  input  logic [RES_W-1:0] res_in,
  input  logic             sample_en,
  input  logic             flush,
  input  logic             clr_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CW-1:0]    out_nibbles,
  output logic [LW-1:0]    fifo_level,
  output logic             overflow
);

  logic [CW-1:0]    nib_cnt;
  logic [CW-1:0]    eff_cnt;
  logic [DW-1:0]    shift_reg;
  logic [DW-1:0]    next_word;
  logic             complete;
  logic             push_req;
  logic             pop;
  logic             accept;
  logic             drop;
  logic             full;
  logic             empty;
  logic [CW+DW-1:0] head;

  // Drop the current sample into its slot so a push on this edge already includes it.
  always_comb begin
    next_word = shift_reg;
    for (int k = 0; k < NIBBLES; k++) begin
      if (sample_en && (nib_cnt == CW'(k))) next_word[RES_W*k +: RES_W] = res_in;
    end
  end

  assign eff_cnt  = nib_cnt + CW'(sample_en);
  assign complete = sample_en && (nib_cnt == CW'(NIBBLES - 1));
  // A flush coinciding with a completing sample is the same single push.
  assign push_req = complete || (flush && (eff_cnt != '0));

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign accept    = push_req && (!full || pop);
  assign drop      = push_req && !accept;

  res_word_fifo #(
    .WIDTH (CW + DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (UserCLK),
    .rst_n     (RESETn),
    .push      (accept),
    .push_data ({eff_cnt, next_word}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  assign out_data    = head[DW-1:0];
  assign out_nibbles = head[CW+DW-1:DW];

  // Nibble assembly: any push attempt, accepted or dropped, restarts an empty word.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn) begin
      nib_cnt   <= '0;
      shift_reg <= '0;
    end else if (push_req) begin
      nib_cnt   <= '0;
      shift_reg <= '0;
    end else if (sample_en) begin
      nib_cnt   <= nib_cnt + CW'(1);
      shift_reg <= next_word;
    end
  end

  // Sticky overflow: a drop wins over a clear on the same edge.
  always_ff @(posedge UserCLK or negedge RESETn) begin
    if (!RESETn)      overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_res_out_packer.sv
// tb/tb_res_out_packer.sv - self-checking bench for res_out_packer against a queue-based model
module tb_res_out_packer;
  import res_io_pkg::*;

  localparam int N     = 8;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic [3:0]  res_in;
  logic        sample_en;
  logic        flush;
  logic        clr_ovf;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_nibbles;
  logic [2:0]  fifo_level;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  res_word_t  m_q[$];
  logic [3:0] m_part[$];
  logic       m_ovf;

  res_out_packer #(.NIBBLES(N), .FIFO_DEPTH(DEPTH)) dut (
    .UserCLK     (clk),
    .RESETn      (rst_n),
    .res_in      (res_in),
    .sample_en   (sample_en),
    .flush       (flush),
    .clr_ovf     (clr_ovf),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_nibbles (out_nibbles),
    .fifo_level  (fifo_level),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    res_word_t h;
    h = (m_q.size() != 0) ? m_q[0] : '0;
    check({tag, ".valid"},   64'(out_valid),   64'(m_q.size() != 0));
    check({tag, ".data"},    64'(out_data),    64'(h.data));
    check({tag, ".nibbles"}, 64'(out_nibbles), 64'(h.count));
    check({tag, ".level"},   64'(fifo_level),  64'(m_q.size()));
    check({tag, ".ovf"},     64'(overflow),    64'(m_ovf));
  endtask

  // One clock: drive inputs, let the model react to the edge, compare just after it.
  task automatic cycle(input logic s, input logic [3:0] r, input logic f,
                       input logic rdy, input logic clr);
    bit do_pop, do_push, dropped;
    res_word_t w;
    sample_en = s; res_in = r; flush = f; out_ready = rdy; clr_ovf = clr;
    @(posedge clk);
    do_pop  = (m_q.size() != 0) && rdy;
    dropped = 1'b0;
    do_push = 1'b0;
    if (s) m_part.push_back(r);
    if (m_part.size() == N || (f && m_part.size() != 0)) begin
      w = '0;
      foreach (m_part[i]) w.data = w.data | (32'(m_part[i]) << (4 * i));
      w.count = 4'(m_part.size());
      if (m_q.size() < DEPTH || do_pop) do_push = 1'b1;
      else dropped = 1'b1;
      m_part.delete();
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    if (do_pop) void'(m_q.pop_front());
    if (do_push) m_q.push_back(w);
    #1;
    check_all("cyc");
    @(negedge clk);
    sample_en = 1'b0; flush = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic samples(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 4'($urandom_range(0, 15)), 1'b0, rdy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; res_in = '0; sample_en = 1'b0; flush = 1'b0;
    clr_ovf = 1'b0; out_ready = 1'b0; m_ovf = 1'b0;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Eight ordered samples form one full word, visible right after the 8th edge.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 4'(i), 1'b0, 1'b1, 1'b0);
    check("t1.data", 64'(out_data), 64'h87654321);
    check("t1.cnt", 64'(out_nibbles), 64'd8);
    check("t1.valid", 64'(out_valid), 64'd1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Partial word flush, then a flush with nothing pending.
    cycle(1'b1, 4'hA, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hB, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 4'hC, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("t2.data", 64'(out_data), 64'h00000CBA);
    check("t2.cnt", 64'(out_nibbles), 64'd3);
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    check("t2.noop", 64'(fifo_level), 64'd1);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Completing sample together with flush yields a single full word.
    samples(7, 1'b0);
    cycle(1'b1, 4'h9, 1'b1, 1'b0, 1'b0);
    check("t3.level", 64'(fifo_level), 64'd1);
    check("t3.cnt", 64'(out_nibbles), 64'd8);
    cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Five words into a four-deep FIFO with the host stalled.
    samples(5 * N, 1'b0);
    check("t4.level", 64'(fifo_level), 64'd4);
    check("t4.ovf", 64'(overflow), 64'd1);
    repeat (4) cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    check("t4.clr", 64'(overflow), 64'd0);

    // Full FIFO: completing sample with a pop on the same edge is accepted.
    samples(4 * N + 7, 1'b0);
    cycle(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
    check("t5.level", 64'(fifo_level), 64'd4);
    check("t5.ovf", 64'(overflow), 64'd0);
    repeat (4) cycle(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-word with two words buffered.
    samples(2 * N + 5, 1'b0);
    #2 rst_n = 1'b0;
    m_q.delete(); m_part.delete(); m_ovf = 1'b0;
    #1 check_all("t6.rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 4'(8 - i), 1'b0, 1'b0, 1'b0);
    check("t6.data", 64'(out_data), 64'h12345678);
    check("t6.level", 64'(fifo_level), 64'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
